// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART constants and receiver state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [15:0] UART_SPEED_DEFAULT = 16'h186a;
    localparam int          UART_DATA_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : Control, serial input and result signals of the UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    import uart_pkg::*;

    logic [15:0]            data;
    logic                   set;
    logic                   rx;
    logic [UART_DATA_W-1:0] data_out;
    logic                   valid;
    logic                   frame_error;
    logic                   busy;

    modport master (
        output data, set, rx,
        input  data_out, valid, frame_error, busy
    );

    modport slave (
        input  data, set, rx,
        output data_out, valid, frame_error, busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Brief    : Two-flop synchronizer for the serial line; resets to idle (1).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic d,
    output logic      q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, LSB first, bit period of cycles_per_bit+1 clocks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    uart_rx_if.slave  bus
);

    logic                   w_rx_s;
    logic [15:0]            w_half;
    logic                   r_rx_d;
    uart_state_t            r_state;
    logic [15:0]            r_cycles_per_bit;
    logic [15:0]            r_cycle_cnt;
    logic [2:0]             r_bit_cnt;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] r_data_out;
    logic                   r_valid;
    logic                   r_frame_error;
    logic                   r_busy;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (w_rx_s)
    );

    assign w_half = r_cycles_per_bit >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_d           <= 1'b1;
            r_state          <= ST_IDLE;
            r_cycles_per_bit <= UART_SPEED_DEFAULT;
            r_cycle_cnt      <= '0;
            r_bit_cnt        <= '0;
            r_shift          <= '0;
            r_data_out       <= '0;
            r_valid          <= 1'b0;
            r_frame_error    <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_rx_d        <= w_rx_s;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
            if (bus.set) begin
                // A speed change abandons any frame in flight.
                r_cycles_per_bit <= bus.data;
                r_state          <= ST_IDLE;
                r_cycle_cnt      <= '0;
                r_bit_cnt        <= '0;
                r_busy           <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_rx_d && !w_rx_s) begin
                            r_state     <= ST_START;
                            r_cycle_cnt <= '0;
                            r_busy      <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (r_cycle_cnt == w_half) begin
                            r_cycle_cnt <= '0;
                            r_bit_cnt   <= '0;
                            if (!w_rx_s) begin
                                r_state <= ST_DATA;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cycle_cnt <= r_cycle_cnt + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (r_cycle_cnt == r_cycles_per_bit) begin
                            r_shift     <= {w_rx_s, r_shift[UART_DATA_W-1:1]};
                            r_cycle_cnt <= '0;
                            r_bit_cnt   <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'(UART_DATA_W - 1)) begin
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_cycle_cnt <= r_cycle_cnt + 16'd1;
                        end
                    end
                    ST_STOP: begin
                        if (r_cycle_cnt == r_cycles_per_bit) begin
                            if (w_rx_s) begin
                                r_data_out <= r_shift;
                                r_valid    <= 1'b1;
                            end else begin
                                r_frame_error <= 1'b1;
                            end
                            r_state     <= ST_IDLE;
                            r_cycle_cnt <= '0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_cycle_cnt <= r_cycle_cnt + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.valid       = r_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Randomized bench for uart_rx with a sample-time reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int HMAX = 60000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Line history indexed by cycle label (label L = interval after rising edge L).
    bit          h_rx   [HMAX];
    bit          h_rst  [HMAX];
    bit          h_set  [HMAX];
    logic [15:0] h_data [HMAX];

    int          lbl = 0;
    bit          m_en = 1'b0;
    bit          m_act = 1'b0;
    int          m_t0;
    logic [15:0] m_n;
    logic [7:0]  m_bits;
    logic [7:0]  m_out;
    bit          e_valid, e_ferr;
    bit          rs, rd;
    int          p_lbl, off, hh, bp, kk;

    int n_valid = 0, n_ferr = 0, n_busy = 0;
    int last_valid_lbl = 0;
    bit last_valid_busy = 1'b0;

    function automatic bit rx_at(input int i);
        return (i < 1) ? 1'b1 : h_rx[i];
    endfunction

    // Reference: a frame starts on a falling edge of the delayed line and is
    // then sampled at t0+H, t0+H+k(N+1) for k=1..8, and the stop at k=9.
    always @(negedge clk) begin
        lbl = lbl + 1;
        if (lbl >= HMAX) begin
            $display("FAIL cycle_budget: label %0d reached limit %0d", lbl, HMAX);
            n_err = n_err + 1;
            $fatal(1, "cycle budget exhausted");
        end
        p_lbl   = lbl - 1;
        e_valid = 1'b0;
        e_ferr  = 1'b0;
        if (p_lbl >= 1 && h_rst[p_lbl]) begin
            m_en  = 1'b1;
            m_act = 1'b0;
            m_n   = UART_SPEED_DEFAULT;
            m_out = 8'h00;
            h_rx[p_lbl] = 1'b1;
            if (p_lbl >= 2) h_rx[p_lbl-1] = 1'b1;
            if (p_lbl >= 3) h_rx[p_lbl-2] = 1'b1;
        end else if (p_lbl >= 1 && h_set[p_lbl]) begin
            m_n   = h_data[p_lbl];
            m_act = 1'b0;
        end else begin
            rs = rx_at(p_lbl - 2);
            rd = rx_at(p_lbl - 3);
            if (!m_act) begin
                if (rd && !rs) begin
                    m_act = 1'b1;
                    m_t0  = lbl;
                end
            end else begin
                off = p_lbl - m_t0;
                hh  = int'(m_n >> 1);
                bp  = int'(m_n) + 1;
                if (off == hh) begin
                    if (rs) m_act = 1'b0;
                end else if (off > hh && ((off - hh) % bp) == 0) begin
                    kk = (off - hh) / bp;
                    if (kk <= 8) begin
                        m_bits[kk-1] = rs;
                    end else begin
                        if (rs) begin
                            e_valid = 1'b1;
                            m_out   = m_bits;
                        end else begin
                            e_ferr = 1'b1;
                        end
                        m_act = 1'b0;
                    end
                end
            end
        end

        h_rx[lbl]   = bus.rx;
        h_rst[lbl]  = reset;
        h_set[lbl]  = bus.set;
        h_data[lbl] = bus.data;

        if (m_en) begin
            n_checks = n_checks + 1;
            if ({bus.valid, bus.frame_error, bus.busy, bus.data_out} !==
                {e_valid, e_ferr, m_act, m_out}) begin
                n_err = n_err + 1;
                $display("FAIL cycle_check @%0d: got v=%b fe=%b busy=%b data=%h, expected v=%b fe=%b busy=%b data=%h",
                         lbl, bus.valid, bus.frame_error, bus.busy, bus.data_out,
                         e_valid, e_ferr, m_act, m_out);
            end
        end

        if (bus.valid === 1'b1) begin
            n_valid         = n_valid + 1;
            last_valid_lbl  = lbl;
            last_valid_busy = bus.busy;
        end
        if (bus.frame_error === 1'b1) n_ferr = n_ferr + 1;
        if (bus.busy === 1'b1) n_busy = n_busy + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_set(input logic [15:0] v);
        bus.set  = 1'b1;
        bus.data = v;
        tick(1);
        bus.set  = 1'b0;
    endtask

    // Leaves the line at the stop level; callers restore idle as needed.
    task automatic send(input logic [7:0] b, input bit stop, input int nclk);
        bus.rx = 1'b0;
        tick(nclk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(nclk);
        end
        bus.rx = stop;
        tick(nclk);
    endtask

    task automatic glitch(input int len);
        bus.rx = 1'b0;
        tick(len);
        bus.rx = 1'b1;
    endtask

    task automatic default_speed_glitch(input string name);
        int b0, v0;
        b0 = n_busy;
        v0 = n_valid + n_ferr;
        glitch(4);
        tick(3300);
        chk(name, n_busy - b0, 3126);
        chk({name, "_pulses"}, n_valid + n_ferr - v0, 0);
    endtask

    int p0, v0, f0, b0, cur_n, sel;

    initial begin
        bus.rx   = 1'b1;
        bus.set  = 1'b0;
        bus.data = 16'h0000;
        reset    = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("reset_outputs", int'({bus.valid, bus.frame_error, bus.busy, bus.data_out}), 0);
        tick(5);

        default_speed_glitch("default_glitch_busy");

        // 0xA5 at 16 clocks per bit
        do_set(16'h000f);
        tick(5);
        p0 = lbl + 1;
        v0 = n_valid;
        send(8'hA5, 1'b1, 16);
        bus.rx = 1'b1;
        tick(20);
        chk("a5_valid_count", n_valid - v0, 1);
        chk("a5_valid_cycle", last_valid_lbl, p0 + 3 + 7 + 9 * 16 + 1);
        chk("a5_busy_at_valid", int'(last_valid_busy), 0);
        chk("a5_data_out", int'(bus.data_out), 8'hA5);

        // Short low pulse: start rejected at the half-bit sample
        b0 = n_busy;
        v0 = n_valid + n_ferr;
        glitch(4);
        tick(40);
        chk("glitch_busy_cycles", n_busy - b0, 8);
        chk("glitch_pulses", n_valid + n_ferr - v0, 0);

        // Break: stop bit low and line held low
        v0 = n_valid;
        f0 = n_ferr;
        send(8'h5A, 1'b0, 16);
        tick(100);
        chk("break_ferr_count", n_ferr - f0, 1);
        chk("break_busy", int'(bus.busy), 0);
        bus.rx = 1'b1;
        tick(30);
        chk("break_valid_count", n_valid - v0, 0);
        chk("break_data_kept", int'(bus.data_out), 8'hA5);

        // Back-to-back frames
        v0 = n_valid;
        f0 = n_ferr;
        send(8'h00, 1'b1, 16);
        send(8'hFF, 1'b1, 16);
        send(8'h3C, 1'b1, 16);
        tick(30);
        chk("b2b_valid_count", n_valid - v0, 3);
        chk("b2b_ferr_count", n_ferr - f0, 0);
        chk("b2b_last_data", int'(bus.data_out), 8'h3C);

        // Reset during bit 3
        bus.rx = 1'b0; tick(16);
        bus.rx = 1'b1; tick(16);
        bus.rx = 1'b0; tick(16);
        bus.rx = 1'b1; tick(16);
        bus.rx = 1'b0; tick(8);
        reset = 1'b1;
        tick(1);
        reset  = 1'b0;
        bus.rx = 1'b1;
        chk("midreset_outputs", int'({bus.valid, bus.frame_error, bus.busy, bus.data_out}), 0);
        tick(10);
        default_speed_glitch("midreset_default_busy");

        // Speed change during bit 3 aborts the frame silently
        do_set(16'h000f);
        tick(5);
        v0 = n_valid;
        f0 = n_ferr;
        bus.rx = 1'b0; tick(16);
        bus.rx = 1'b0; tick(16);
        bus.rx = 1'b1; tick(16);
        bus.rx = 1'b1; tick(16);
        bus.rx = 1'b0; tick(8);
        do_set(16'h0007);
        bus.rx = 1'b1;
        chk("midset_busy", int'(bus.busy), 0);
        tick(20);
        chk("midset_pulses", n_valid + n_ferr - v0 - f0, 0);
        send(8'h96, 1'b1, 8);
        bus.rx = 1'b1;
        tick(20);
        chk("newspeed_valid_count", n_valid - v0, 1);
        chk("newspeed_data_out", int'(bus.data_out), 8'h96);

        // Randomized traffic against the model
        cur_n = 7;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cur_n = $urandom_range(3, 24);
                do_set(16'(cur_n));
                tick($urandom_range(0, 3));
            end
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                glitch($urandom_range(1, cur_n / 2));
            end else if (sel == 1) begin
                send(8'($urandom), 1'b0, cur_n + 1);
                bus.rx = 1'b1;
            end else begin
                send(8'($urandom), 1'b1, cur_n + 1);
            end
            bus.rx = 1'b1;
            tick($urandom_range(0, cur_n));
        end
        tick(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver: 8N1 framing, LSB first, programmable bit period, running on the system clock. Counterpart to `uart_tx` and shares its speed-programming convention: a `set` strobe loads `cycles_per_bit` from `data`. One bit lasts `cycles_per_bit + 1` clocks, so a `uart_rx`/`uart_tx` pair loaded with the same value agrees bit-for-bit. Sits between the chip's serial input pad and the command/data decoder.

## Interface
- `UART_SPEED_DEFAULT`, 16'h186a, reset value of `cycles_per_bit` (N); bit period = N+1 clocks.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `data`  in  16  new N value, sampled when `set` = 1.
- `set`  in  1  load strobe: `cycles_per_bit <= data`.
- `rx`  in  1  asynchronous serial line, idle high.
- `data_out`  out  8  last correctly framed byte; holds until the next good frame.
- `valid`  out  1  one-cycle pulse when `data_out` updates.
- `frame_error`  out  1  one-cycle pulse when the stop bit samples 0.
- `busy`  out  1  high in START, DATA and STOP.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. A third flop `rx_d` holds the previous `rx_s` for falling-edge detection.
- Let H = N >> 1. Supported N ≥ 3; smaller values give undefined results.
- Reset values: `data_out` = 0, `valid` = 0, `frame_error` = 0, `busy` = 0, sync flops = 1, state = IDLE, counters = 0, N = `UART_SPEED_DEFAULT`.
- Priority: `reset` > `set` > FSM.
  - `set` loads N, forces IDLE and clears the counters.
  - No `valid` or `frame_error` pulse on a `set` cycle.
  - Asserting `set` mid-frame aborts that frame silently.
- FSM states:
  - IDLE: when `rx_d` = 1 and `rx_s` = 0, go to START with `cycle_counter` = 0. Only a falling edge starts a frame, so a held-low line (break) never retriggers.
  - START: count up. At `cycle_counter` == H, sample `rx_s`. If 0, go to DATA with counter = 0 and `bit_counter` = 0. If 1, the start was a glitch: return to IDLE, no pulse.
  - DATA: at `cycle_counter` == N, shift `rx_s` into the shift register (MSB side, shifting right, so bit 0 lands at the LSB), set counter = 0, and increment `bit_counter`. After the 8th sample (`bit_counter` == 7), go to STOP.
  - STOP: at `cycle_counter` == N, sample `rx_s`.
    - If 1: `data_out <= shift`, pulse `valid`.
    - If 0: pulse `frame_error`; `data_out` unchanged.
    - Either way, return to IDLE.
- `cycle_counter` is 16 bits and never exceeds N, so it cannot wrap. `bit_counter` is 3 bits.
- Changing N takes effect on the next frame. Because `set` aborts, it is never applied mid-frame.

## Timing
- Let t0 = the first START cycle, i.e. 3 clocks after the `rx` pin falls (2 synchronizer clocks + 1 detection clock).
- Start validation sample: t0 + H.
- Data bit k (k = 0..7) sampled at t0 + H + (k+1)(N+1).
- Stop sampled at t0 + H + 9(N+1). `valid`/`frame_error` are high for exactly the next cycle, and `busy` falls in that same cycle.
- Back-to-back frames: IDLE is re-entered before mid-stop + ½ bit, so a start edge immediately after the stop bit is caught.
- Pulse outputs are registered, never combinational from `rx`.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_SPEED_DEFAULT` (16'h186a), also adopted by `uart_tx`;
  - the 2-bit state encoding: IDLE = 00, START = 01, DATA = 10, STOP = 11;
  - the UART data width (8).
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1.

## Test plan
- Set N = 15 (`data` = 16'h000f, `set` for 1 clock), drive 0xA5 at 16 clk/bit → `valid` for exactly 1 cycle at t0 + 7 + 9·16 + 1, `data_out` = 0xA5, `frame_error` = 0, `busy` falls in that cycle.
- Loopback `uart_tx` → `uart_rx`, both at default N, bytes 0x00, 0xFF, 0x3C back-to-back → three `valid` pulses with matching `data_out`, no `frame_error`.
- N = 15, `rx` low for 4 clocks then high → START entered, sample at H = 7 sees 1 → IDLE, `busy` high for 8 clocks, no pulses.
- N = 15, send 0x5A then hold `rx` low through the stop bit and 100 more clocks → `frame_error` pulse once, `data_out` keeps its previous value, no new frame until `rx` goes high and then falls again.
- Mid-DATA (bit 3), pulse `reset` → next cycle all outputs at reset values, N = 16'h186a. Mid-DATA, pulse `set` with 16'h0007 → IDLE, no pulse; next frame at 8 clk/bit is received correctly.
